// File: rtl/branch_predict_fetch.sv
// ---------------------------------------------------------------------------
// branch_predict_fetch
//
// Fetch-stage front end for the 5-stage RISC-V pipeline. Owns the fetch PC
// and next-PC selection. A direct-mapped branch target buffer (BTB) with
// 2-bit saturating counters lets taken branches/jumps redirect fetch in F.
// The E stage trains the BTB with resolved outcomes.
//
// Parameters:
//   XLEN     - address / PC width
//   ENTRIES  - number of BTB entries (power of two, 2..256)
//   RESET_PC - PC loaded on reset
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   stall_f          in   hold PC
//   redirect_e       in   redirect from E (highest priority)
//   redirect_pc_e    in   PC to fetch after a redirect
//   update_en_e      in   control-transfer instruction resolved in E
//   update_pc_e      in   PC of the resolved instruction
//   update_taken_e   in   resolved direction
//   update_target_e  in   resolved target
//   pc_f             out  current fetch PC
//   pc_plus4_f       out  pc_f + 4
//   pred_taken_f     out  BTB hit with counter >= 2
//   pred_target_f    out  predicted target (meaningful when pred_taken_f)
//   branch_count     out  resolved updates since reset
//   mispredict_count out  redirects since reset
// ---------------------------------------------------------------------------
module branch_predict_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            update_en_e,
  input  logic [XLEN-1:0] update_pc_e,
  input  logic            update_taken_e,
  input  logic [XLEN-1:0] update_target_e,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned     IDX     = $clog2(ENTRIES);
  localparam int unsigned     TAGW    = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Fetch PC state
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_q;
  logic [XLEN-1:0] pc_plus4_d;

  // BTB storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Event counters
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  // Lookup side
  logic [IDX-1:0]  lk_idx_s;
  logic [TAGW-1:0] lk_tag_s;
  logic            lk_hit_s;
  logic            pred_taken_s;

  // Update side
  logic [IDX-1:0]  up_idx_s;
  logic [TAGW-1:0] up_tag_s;
  logic            up_hit_s;
  logic            wr_en_s;
  logic [1:0]      wr_ctr_s;
  logic [XLEN-1:0] wr_target_s;

  // Byte-offset bits of the update PC play no part in indexing
  logic unused_s;
  assign unused_s = ^update_pc_e[1:0];

  // Combinational BTB lookup from the current fetch PC
  assign lk_idx_s     = pc_q[IDX+1:2];
  assign lk_tag_s     = pc_q[XLEN-1:IDX+2];
  assign lk_hit_s     = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign pred_taken_s = lk_hit_s && ctr_q[lk_idx_s][1];

  // Next-PC selection: redirect > stall > prediction > sequential
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (redirect_e) begin
      pc_d = redirect_pc_e;
    end else if (stall_f) begin
      pc_d = pc_q;
    end else if (pred_taken_s) begin
      pc_d = target_q[lk_idx_s];
    end else begin
      pc_d = pc_q + PC_STEP;
    end
    pc_plus4_d = pc_d + PC_STEP;
  end

  // PC and PC+4 registers (PC+4 kept registered alongside the PC)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_STEP;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign up_idx_s = update_pc_e[IDX+1:2];
  assign up_tag_s = update_pc_e[XLEN-1:IDX+2];
  assign up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);

  // BTB training decision for the entry addressed by the resolved PC
  always_comb begin
    wr_en_s     = 1'b0;
    wr_ctr_s    = ctr_q[up_idx_s];
    wr_target_s = target_q[up_idx_s];
    if (update_en_e) begin
      if (up_hit_s) begin
        wr_en_s = 1'b1;
        if (update_taken_e) begin
          wr_ctr_s    = (ctr_q[up_idx_s] == 2'd3) ? 2'd3 : (ctr_q[up_idx_s] + 2'd1);
          wr_target_s = update_target_e;
        end else begin
          wr_ctr_s    = (ctr_q[up_idx_s] == 2'd0) ? 2'd0 : (ctr_q[up_idx_s] - 2'd1);
        end
      end else if (update_taken_e) begin
        // Allocate weakly-taken, evicting whatever aliases at this index
        wr_en_s     = 1'b1;
        wr_ctr_s    = 2'd2;
        wr_target_s = update_target_e;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // BTB storage; writes land at the edge so same-cycle lookups see old data
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd0;
      end
    end else begin
      if (wr_en_s) begin
        valid_q[up_idx_s]  <= 1'b1;
        tag_q[up_idx_s]    <= up_tag_s;
        target_q[up_idx_s] <= wr_target_s;
        ctr_q[up_idx_s]    <= wr_ctr_s;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  // Event counters, free-running modulo 2^32; stall does not gate them
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      branch_count_q     <= update_en_e ? (branch_count_q + 32'd1) : branch_count_q;
      mispredict_count_q <= redirect_e ? (mispredict_count_q + 32'd1) : mispredict_count_q;
    end
  end

  assign pc_f             = pc_q;
  assign pc_plus4_f       = pc_plus4_q;
  assign pred_taken_f     = pred_taken_s;
  assign pred_target_f    = target_q[lk_idx_s];
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_fetch.sv
module tb_branch_predict_fetch;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic        update_en_e;
  logic [31:0] update_pc_e;
  logic        update_taken_e;
  logic [31:0] update_target_e;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predict_fetch #(
    .XLEN(32), .ENTRIES(ENTRIES), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f),
    .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
    .update_en_e(update_en_e), .update_pc_e(update_pc_e),
    .update_taken_e(update_taken_e), .update_target_e(update_target_e),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  // Reference model: BTB as an associative array keyed by index; presence = valid
  typedef struct {
    logic [31:0] tag;
    logic [31:0] target;
    int          ctr;
  } ent_t;
  ent_t btb [int];

  logic [31:0] m_pc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(ENTRIES));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (32'd4 * 32'(ENTRIES));
  endfunction

  function automatic void predict(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    pt  = 1'b0;
    tgt = 32'h0;
    if (btb.exists(i)) begin
      if (btb[i].tag == tag_of(pc) && btb[i].ctr >= 2) begin
        pt  = 1'b1;
        tgt = btb[i].target;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs that were applied
  task automatic model_step();
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] npc;
    int          i;
    if (reset) begin
      btb.delete();
      m_pc = 32'h0;
      m_bc = 32'd0;
      m_mc = 32'd0;
    end else begin
      predict(m_pc, pt, ptg);
      if (redirect_e)   npc = redirect_pc_e;
      else if (stall_f) npc = m_pc;
      else if (pt)      npc = ptg;
      else              npc = m_pc + 32'd4;
      if (update_en_e) begin
        m_bc = m_bc + 32'd1;
        i = idx_of(update_pc_e);
        if (btb.exists(i) && btb[i].tag == tag_of(update_pc_e)) begin
          if (update_taken_e) begin
            btb[i].ctr    = (btb[i].ctr + 1 > 3) ? 3 : btb[i].ctr + 1;
            btb[i].target = update_target_e;
          end else begin
            btb[i].ctr = (btb[i].ctr - 1 < 0) ? 0 : btb[i].ctr - 1;
          end
        end else if (update_taken_e) begin
          btb[i] = '{tag: tag_of(update_pc_e), target: update_target_e, ctr: 2};
        end
      end
      if (redirect_e) m_mc = m_mc + 32'd1;
      m_pc = npc;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    predict(m_pc, e.pt, e.ptg);
    e.bc  = m_bc;
    e.mc  = m_mc;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive inputs, let the edge happen, record expectation
  task automatic cyc(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                     input logic ue, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    reset           = rst;
    stall_f         = st;
    redirect_e      = rd;
    redirect_pc_e   = rpc;
    update_en_e     = ue;
    update_pc_e     = upc;
    update_taken_e  = ut;
    update_target_e = utg;
    @(posedge clk);
    #1;
    model_step();
    push_expect();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_word();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Monitor: pop the oldest expectation and compare away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_f", pc_f, e.pc);
        chk("pc_plus4_f", pc_plus4_f, e.pc4);
        chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e.pt});
        if (e.pt) chk("pred_target_f", pred_target_f, e.ptg);
        chk("branch_count", branch_count, e.bc);
        chk("mispredict_count", mispredict_count, e.mc);
      end
    end
  end

  initial begin
    m_pc = 32'h0;
    m_bc = 32'd0;
    m_mc = 32'd0;
    // Reset and free-run
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) idle();
    // Cold train 0x40 -> 0x10, then fetch 0x40
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    // Hysteresis: up to 3, down to 2 (still taken), down to 1 (not taken)
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    // Alias at index 0: retrain 0x40 taken, then fetch 0x80, then replace with 0x80
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h200);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    // Priority: redirect beats stall, then stall holds
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    // Same-cycle update at the current fetch index (stalled, update not blocked)
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h300);
    idle();
    idle();
    // PC wrap modulo 2^32
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    // Reset during training
    cyc(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h0, 1'b1, 32'h40);
    idle();
    idle();
    // Randomized traffic over a small address window to exercise hits and aliases
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0), rand_word(),
          ($urandom_range(0, 1) == 1), rand_word(),
          ($urandom_range(0, 2) != 0), rand_word());
    end
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_fetch.md
# branch_predict_fetch

Parametrised fetch-stage front end for the 5-stage RISC-V pipeline. It owns the PC register and next-PC selection, and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Taken branches and jumps can therefore redirect fetch in F instead of always costing a flush at resolution in E. It sits between the hazard unit (stall/redirect) and the instruction memory; the E stage trains it with resolved outcomes.

## Interface
Parameters:
- XLEN, 32, address/PC width.
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- RESET_PC, 0, PC value loaded on reset.
- IDX = log2(ENTRIES) (derived); index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_f  in  1  hold PC (load-use hazard).
- redirect_e  in  1  mispredict/redirect from E; highest priority.
- redirect_pc_e  in  XLEN  correct PC to fetch next.
- update_en_e  in  1  a control-transfer instruction resolved in E this cycle.
- update_pc_e  in  XLEN  PC of that instruction.
- update_taken_e  in  1  resolved direction.
- update_target_e  in  XLEN  resolved target.
- pc_f  out  XLEN  current fetch PC (to instruction memory).
- pc_plus4_f  out  XLEN  pc_f + 4.
- pred_taken_f  out  1  BTB hit and counter ≥ 2; carried down the pipe.
- pred_target_f  out  XLEN  predicted target (valid only when pred_taken_f).
- branch_count  out  32  resolved updates since reset.
- mispredict_count  out  32  redirects since reset.

## Operation
- Each entry holds: valid, tag, target[XLEN-1:0], ctr[1:0].
- Lookup is combinational from pc_f. Hit = valid && tag match. pred_taken_f = hit && ctr[1]. pred_target_f = entry target.
- Next PC priority: redirect_e → redirect_pc_e; else stall_f → pc_f unchanged; else pred_taken_f → pred_target_f; else pc_plus4_f.
- Update, when update_en_e is asserted, at the entry indexed by update_pc_e:
  - Hit and taken: ctr saturating increment (max 3); target ← update_target_e.
  - Hit and not taken: ctr saturating decrement (min 0); target kept.
  - Miss and taken: allocate. valid=1, tag written, target written, ctr=2 (weakly taken). Any aliasing entry is replaced.
  - Miss and not taken: no change.
- Counters:
  - branch_count increments on update_en_e.
  - mispredict_count increments on redirect_e.
  - Both wrap modulo 2^32.
- Arithmetic: pc + 4 wraps modulo 2^XLEN. No alignment checks; pc[1:0] are ignored by indexing.
- The block does not decide mispredicts; the hazard unit compares the pred_* values carried to E with the resolved outcome and drives redirect_e.

## Timing
- Reset (synchronous):
  - pc_f = RESET_PC, pc_plus4_f = RESET_PC+4.
  - All valid bits cleared, so pred_taken_f = 0.
  - Both counters = 0.
- Reset asserted mid-operation takes effect at the next edge, overriding redirect/stall/update in that cycle.
- pc_f updates one cycle after its cause (redirect, prediction, increment). Lookup outputs have zero latency relative to pc_f.
- BTB writes commit at the clock edge. A lookup in the same cycle as an update to the same index sees the old contents; the new contents are visible from the next cycle.
- Simultaneous cases:
  - redirect_e with stall_f: redirect wins.
  - redirect_e with update_en_e: both take effect.
  - stall_f does not block BTB updates or counters.
- Counters update on the same edge as the event.

## Test plan
1. Reset with RESET_PC=0x0 → pc_f=0x0, pred_taken_f=0, counters 0. Free-running with no stall gives pc_f 0x0,0x4,0x8,0xC on successive cycles.
2. Cold train: update_en_e=1, pc=0x40, taken=1, target=0x10, then fetch reaches 0x40 → pred_taken_f=1, pred_target_f=0x10, next pc_f=0x10. Entry 0 has ctr=2.
3. Hysteresis: drive two more taken updates for 0x40 (ctr=3), then one not-taken (ctr=2) → still predicted taken. A second not-taken (ctr=1) → at 0x40 pred_taken_f=0, next pc_f=0x44.
4. Alias: with 0x40 trained, fetch 0x80 (same index 0, different tag) → pred_taken_f=0. A taken update at 0x80 (target 0x200) replaces the entry; 0x40 then misses.
5. Priority: stall_f=1 with redirect_e=1, redirect_pc_e=0x100 → pc_f=0x100 next cycle, mispredict_count=1. stall_f=1 alone holds pc_f for 3 cycles.
6. Same-cycle update at the current pc_f index → the prediction that cycle uses the old entry; the new entry is effective next cycle. Reset asserted during training → all entries invalid, counters 0.
